// File: rtl/vlsu_ld_collect.sv
// Vector load result collector: gathers per-element load data into one VRF line and writes it back.
// Optional tail-zeroing of the whole register line: define SCR1_VLSU_LDCOL_TAIL_ZERO_EN.
module vlsu_ld_collect #(
    parameter int unsigned LANE = 8,
    parameter int unsigned ELEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           vl,
    input  logic [4:0]           vd,
    input  logic [LANE-1:0]      elem_wreq,
    input  logic [LANE*ELEN-1:0] elem_data,
    input  logic                 elem_err,
    output logic                 vrf_we,
    output logic [4:0]           vrf_waddr,
    output logic [LANE*ELEN-1:0] vrf_wdata,
    output logic [LANE-1:0]      vrf_wmask,
    input  logic                 vrf_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [3:0] LANE_VL = 4'(LANE);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    state_e                state_q;
    logic [3:0]            vl_q;
    logic [3:0]            cnt_q;
    logic [4:0]            vd_q;
    logic [LANE*ELEN-1:0]  buf_q;
    logic [LANE-1:0]       mask_q;
    logic                  err_q;

    logic [3:0]            vl_clamp;
    logic [LANE-1:0]       acc;
    logic [LANE-1:0]       fresh;
    logic [3:0]            cnt_inc;
    logic [3:0]            cnt_nxt;
    logic [LANE*ELEN-1:0]  buf_nxt;

    // Qualify requests against vl; only first arrival of a lane advances the count.
    always_comb begin
        vl_clamp = (vl > LANE_VL) ? LANE_VL : vl;
        acc      = '0;
        fresh    = '0;
        cnt_inc  = '0;
        buf_nxt  = buf_q;
        for (int i = 0; i < LANE; i++) begin
            acc[i]   = elem_wreq[i] & (4'(i) < vl_q);
            fresh[i] = acc[i] & ~mask_q[i];
            cnt_inc  = cnt_inc + {3'b000, fresh[i]};
            if (acc[i]) begin
                buf_nxt[i*ELEN +: ELEN] = elem_data[i*ELEN +: ELEN];
            end
        end
        cnt_nxt = cnt_q + cnt_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vl_q    <= '0;
            cnt_q   <= '0;
            vd_q    <= '0;
            buf_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        vl_q    <= vl_clamp;
                        vd_q    <= vd;
                        buf_q   <= '0;
                        mask_q  <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= (vl_clamp == 4'd0) ? StDone : StCollect;
                    end
                end
                StCollect: begin
                    if (elem_err && (|elem_wreq)) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        buf_q  <= buf_nxt;
                        mask_q <= mask_q | acc;
                        cnt_q  <= cnt_nxt;
                        if (cnt_nxt == vl_q) begin
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (vrf_ack) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vrf_we    = (state_q == StWrite);
    assign vrf_waddr = vd_q;
    // Buffer is cleared on start and only filled at masked lanes, so unmasked lanes read as zero.
    assign vrf_wdata = buf_q;
`ifdef SCR1_VLSU_LDCOL_TAIL_ZERO_EN
    assign vrf_wmask = (state_q == StWrite) ? {LANE{1'b1}} : mask_q;
`else
    assign vrf_wmask = mask_q;
`endif
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = (state_q == StDone) & err_q;

endmodule

// File: tb/tb_vlsu_ld_collect.sv
// Directed self-checking bench for vlsu_ld_collect.
module tb_vlsu_ld_collect;

    localparam int unsigned LANE = 8;
    localparam int unsigned ELEN = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [3:0]           vl;
    logic [4:0]           vd;
    logic [LANE-1:0]      elem_wreq;
    logic [LANE*ELEN-1:0] elem_data;
    logic                 elem_err;
    logic                 vrf_we;
    logic [4:0]           vrf_waddr;
    logic [LANE*ELEN-1:0] vrf_wdata;
    logic [LANE-1:0]      vrf_wmask;
    logic                 vrf_ack;
    logic                 busy;
    logic                 done;
    logic                 err;

    int errors = 0;
    int checks = 0;

    vlsu_ld_collect #(.LANE(LANE), .ELEN(ELEN)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vl        (vl),
        .vd        (vd),
        .elem_wreq (elem_wreq),
        .elem_data (elem_data),
        .elem_err  (elem_err),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .vrf_wmask (vrf_wmask),
        .vrf_ack   (vrf_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_mask(input logic [7:0] m);
`ifdef SCR1_VLSU_LDCOL_TAIL_ZERO_EN
        return 8'hFF;
`else
        return m;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_txn(input logic [3:0] n, input logic [4:0] d);
        start = 1'b1;
        vl    = n;
        vd    = d;
        tick();
        start = 1'b0;
    endtask

    // One-hot element; other lanes carry junk that must never be captured.
    task automatic send(input int unsigned idx, input logic [31:0] d, input logic e);
        elem_wreq      = '0;
        elem_wreq[idx] = 1'b1;
        elem_err       = e;
        for (int j = 0; j < LANE; j++) begin
            elem_data[j*ELEN +: ELEN] = (j == idx) ? d : (32'hDEAD_0000 | j);
        end
        tick();
        elem_wreq = '0;
        elem_err  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vl        = '0;
        vd        = '0;
        elem_wreq = '0;
        elem_data = '0;
        elem_err  = 1'b0;
        vrf_ack   = 1'b0;
        tick();
        tick();
        check_eq("rst_we",    vrf_we,    0);
        check_eq("rst_waddr", vrf_waddr, 0);
        check_eq("rst_wdata", vrf_wdata, 0);
        check_eq("rst_wmask", vrf_wmask, 0);
        check_eq("rst_busy",  busy,      0);
        check_eq("rst_done",  done,      0);
        check_eq("rst_err",   err,       0);
        rst_n = 1'b1;
        tick();

        // vl=4, in-order elements, ack held high throughout
        vrf_ack = 1'b1;
        begin_txn(4'd4, 5'd3);
        check_eq("t1_busy", busy, 1);
        send(0, 32'h10, 1'b0);
        send(1, 32'h11, 1'b0);
        send(2, 32'h12, 1'b0);
        check_eq("t1_we_early", vrf_we, 0);
        send(3, 32'h13, 1'b0);
        check_eq("t1_we",    vrf_we,    1);
        check_eq("t1_waddr", vrf_waddr, 3);
        check_eq("t1_wdata", vrf_wdata, {128'h0, 32'h13, 32'h12, 32'h11, 32'h10});
        check_eq("t1_wmask", vrf_wmask, exp_mask(8'h0F));
        tick();
        check_eq("t1_done", done, 1);
        check_eq("t1_err",  err,  0);
        check_eq("t1_we_off", vrf_we, 0);
        tick();
        check_eq("t1_idle", busy, 0);
        vrf_ack = 1'b0;

        // vl=2, out-of-order, ack withheld three cycles; stray start/element during write
        begin_txn(4'd2, 5'd7);
        send(1, 32'h21, 1'b0);
        send(0, 32'h20, 1'b0);
        check_eq("t2_we_c1", vrf_we, 1);
        check_eq("t2_wdata_c1", vrf_wdata, {192'h0, 32'h21, 32'h20});
        check_eq("t2_wmask", vrf_wmask, exp_mask(8'h03));
        start = 1'b1;
        vl    = 4'd0;
        elem_wreq = 8'h01;
        elem_data = {LANE{32'hEE}};
        tick();
        start = 1'b0;
        elem_wreq = '0;
        check_eq("t2_we_c2", vrf_we, 1);
        check_eq("t2_wdata_c2", vrf_wdata, {192'h0, 32'h21, 32'h20});
        tick();
        check_eq("t2_we_c3", vrf_we, 1);
        tick();
        check_eq("t2_we_c4", vrf_we, 1);
        check_eq("t2_waddr", vrf_waddr, 7);
        check_eq("t2_done_early", done, 0);
        vrf_ack = 1'b1;
        tick();
        vrf_ack = 1'b0;
        check_eq("t2_done", done, 1);
        check_eq("t2_we_off", vrf_we, 0);
        tick();
        check_eq("t2_idle", busy, 0);
        check_eq("t2_no_queue", done, 0);

        // vl=3, lane 0 rewritten before completion
        begin_txn(4'd3, 5'd1);
        send(0, 32'hA, 1'b0);
        send(0, 32'hB, 1'b0);
        send(1, 32'h31, 1'b0);
        check_eq("t3_we_early", vrf_we, 0);
        send(2, 32'h32, 1'b0);
        check_eq("t3_we", vrf_we, 1);
        check_eq("t3_wdata", vrf_wdata, {160'h0, 32'h32, 32'h31, 32'hB});
        vrf_ack = 1'b1;
        tick();
        vrf_ack = 1'b0;
        check_eq("t3_done", done, 1);
        tick();

        // vl=4, error on element 1, then a vl=0 transaction
        begin_txn(4'd4, 5'd2);
        send(0, 32'h40, 1'b0);
        send(1, 32'h41, 1'b1);
        check_eq("t4_done", done, 1);
        check_eq("t4_err",  err,  1);
        check_eq("t4_we",   vrf_we, 0);
        tick();
        check_eq("t4_idle", busy, 0);
        begin_txn(4'd0, 5'd4);
        check_eq("t5_done", done, 1);
        check_eq("t5_err",  err,  0);
        check_eq("t5_we",   vrf_we, 0);
        tick();
        check_eq("t5_idle", busy, 0);

        // vl=12 clamps to 8; first four lanes arrive as one multi-hot request
        begin_txn(4'd12, 5'd9);
        elem_wreq = 8'h0F;
        elem_data = {32'hDEAD_0007, 32'hDEAD_0006, 32'hDEAD_0005, 32'hDEAD_0004,
                     32'h53, 32'h52, 32'h51, 32'h50};
        tick();
        elem_wreq = '0;
        send(4, 32'h54, 1'b0);
        send(5, 32'h55, 1'b0);
        send(6, 32'h56, 1'b0);
        check_eq("t6_we_early", vrf_we, 0);
        send(7, 32'h57, 1'b0);
        check_eq("t6_we", vrf_we, 1);
        check_eq("t6_wdata", vrf_wdata, {32'h57, 32'h56, 32'h55, 32'h54,
                                         32'h53, 32'h52, 32'h51, 32'h50});
        check_eq("t6_wmask", vrf_wmask, 8'hFF);
        vrf_ack = 1'b1;
        tick();
        vrf_ack = 1'b0;
        check_eq("t6_done", done, 1);
        tick();

        // vl=5: element 7 out of range must be ignored
        begin_txn(4'd5, 5'd4);
        send(7, 32'h67, 1'b0);
        send(0, 32'h60, 1'b0);
        send(1, 32'h61, 1'b0);
        send(2, 32'h62, 1'b0);
        send(3, 32'h63, 1'b0);
        check_eq("t7_we_early", vrf_we, 0);
        send(4, 32'h64, 1'b0);
        check_eq("t7_we", vrf_we, 1);
        check_eq("t7_wdata", vrf_wdata, {96'h0, 32'h64, 32'h63, 32'h62, 32'h61, 32'h60});
        check_eq("t7_wmask", vrf_wmask, exp_mask(8'h1F));
        vrf_ack = 1'b1;
        tick();
        vrf_ack = 1'b0;
        check_eq("t7_done", done, 1);
        tick();

        // Reset while writing drops the write without done
        begin_txn(4'd1, 5'd5);
        send(0, 32'h77, 1'b0);
        check_eq("t8_we", vrf_we, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("t8_we_rst",    vrf_we,    0);
        check_eq("t8_waddr_rst", vrf_waddr, 0);
        check_eq("t8_wdata_rst", vrf_wdata, 0);
        check_eq("t8_wmask_rst", vrf_wmask, 0);
        check_eq("t8_busy_rst",  busy,      0);
        check_eq("t8_done_rst",  done,      0);
        tick();
        check_eq("t8_no_done", done, 0);
        begin_txn(4'd1, 5'd6);
        send(0, 32'h88, 1'b0);
        check_eq("t8b_waddr", vrf_waddr, 6);
        check_eq("t8b_wdata", vrf_wdata, {224'h0, 32'h88});
        vrf_ack = 1'b1;
        tick();
        vrf_ack = 1'b0;
        check_eq("t8b_done", done, 1);
        check_eq("t8b_err",  err,  0);
        tick();
        check_eq("t8b_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vlsu_ld_collect.md
# vlsu_ld_collect

Vector load result collector, directly downstream of the vector load/store unit. It captures per-element load data and one-hot element write requests and assembles them into one vector-register line. After `vl` elements arrive it issues a single handshaked write to the vector register file (VRF) write port. It also reports completion and error status to the vector execution unit (VEXU).

## Interface
Parameters:
- `LANE`, 8, number of 32-bit elements per vector register; `vl` is clamped to this value.
- `ELEN`, 32, element width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  opens a new load transaction; sampled only in IDLE.
- `vl`  in  4  element count, captured on `start`; values above `LANE` are clamped to `LANE`.
- `vd`  in  5  destination register index, captured on `start`.
- `elem_wreq`  in  LANE  per-element write request from the VLSU, normally one-hot.
- `elem_data`  in  LANE*ELEN  per-element load data; lane i is valid when `elem_wreq[i]` is set.
- `elem_err`  in  1  memory error on the current element response.
- `vrf_we`  out  1  VRF write request.
- `vrf_waddr`  out  5  VRF write address (the captured `vd`).
- `vrf_wdata`  out  LANE*ELEN  assembled register line.
- `vrf_wmask`  out  LANE  per-element write enable.
- `vrf_ack`  in  1  VRF accepts the write this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid only with `done`; set means the transaction was aborted.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE, `start`=1:
  - Capture `vl` (clamped), `vd`; clear the buffer, mask, count and error flag.
  - If `vl`=0, go to DONE; otherwise go to COLLECT.
- IDLE, `start`=0: stay in IDLE. `elem_wreq` is ignored in IDLE, including the cycle `start` is sampled.
- COLLECT, normal element (no error):
  - For each set bit i with i < `vl`: write `elem_data[i]` into buffer lane i.
  - If mask bit i was 0, set it and increment the count.
  - A repeated index overwrites the lane data without incrementing the count.
  - Set bits with i >= `vl` are ignored.
  - A multi-hot request accepts every qualifying bit in the same cycle.
- COLLECT, `elem_err`=1 with any `elem_wreq`: discard that element, set the error flag, go to DONE. No VRF write occurs.
- COLLECT exit: when the count (including this cycle's increments) equals `vl`, go to WRITE.
- WRITE:
  - Hold `vrf_we`=1 with stable `vrf_waddr`, `vrf_wdata`, `vrf_wmask` until `vrf_ack`=1, then go to DONE.
  - Element inputs are ignored.
- DONE: `done`=1 and `err`=error flag for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `vrf_wdata` lanes whose mask bit is 0 are driven as zero.

## Timing
- Reset values: `vrf_we`=0, `vrf_waddr`=0, `vrf_wdata`=0, `vrf_wmask`=0, `busy`=0, `done`=0, `err`=0. Reset state is IDLE with buffer, mask, count and error flag cleared.
- All outputs are registered or decoded from state only; there is no combinational path from `elem_*` to any output.
- `start` at cycle t gives `busy`=1 from t+1.
- Last element at cycle t:
  - `vrf_we`=1 from t+1.
  - If `vrf_ack` is present at t+1, `done`=1 at t+2 and IDLE at t+3.
- `vl`=0: `start` at t gives `done`=1 at t+1, then IDLE at t+2.
- Error at cycle t: `done`=`err`=1 at t+1, with no `vrf_we` pulse.
- `vrf_ack` while `vrf_we`=0 has no effect.
- Reset asserted in any state: return to IDLE on the next edge, drop any pending write, and raise no `done`.

## Configuration
- `SCR1_VLSU_LDCOL_TAIL_ZERO_EN`
  - Defined: `vrf_wmask` is all ones in WRITE. Lanes >= `vl` and never-received lanes are written as zero (tail-zeroing).
  - Undefined: `vrf_wmask` equals the received-element mask, so unreceived lanes of the destination register keep their previous contents.

## Test plan
- `start` with `vl`=4, `vd`=3; elements 0..3 one-hot on consecutive cycles with data 0x10..0x13; `vrf_ack` held 1 → one `vrf_we` cycle, `vrf_waddr`=3, lanes 0..3 = 0x10..0x13, mask 0x0F (or 0xFF with the macro defined); `done`=1, `err`=0.
- `vl`=2; element 1 then element 0 (out of order); `vrf_ack` withheld 3 cycles → `vrf_we` stays high for 4 cycles with stable data, then `done` on the cycle after the ack.
- `vl`=3; element 0 sent twice (0xA, then 0xB), then elements 1, 2 → lane 0 = 0xB; the write occurs only after element 2.
- `vl`=4; element 1 arrives with `elem_err`=1 → `done`=`err`=1 on the next cycle, no `vrf_we`; a following `start` is accepted.
- `vl`=0 → `done` one cycle after `start`, no write. `vl`=12 → behaves as 8. Element 7 sent with `vl`=5 → ignored.
- `rst_n` low for one cycle while in WRITE → outputs return to their reset values, no `done`; the next transaction completes normally.
